// File: rtl/rc4_prga_decrypt.sv
// RC4 pseudo-random generation and decryption stage.
// Walks the key-scheduled S memory to produce the keystream, XORs it with the
// encrypted message ROM, stores the plaintext in the decrypted-message RAM and
// flags whether every stored byte is a lowercase letter or a space.
module rc4_prga_decrypt #(
    parameter int MSG_LEN     = 32,
    parameter int MSG_AW      = 5,
    parameter bit EARLY_ABORT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              finish,
    output logic              msg_ok,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wen,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wen
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_INC_I = 4'd1;
    localparam logic [3:0] ST_RD_I  = 4'd2;
    localparam logic [3:0] ST_LAT_I = 4'd3;
    localparam logic [3:0] ST_RD_J  = 4'd4;
    localparam logic [3:0] ST_LAT_J = 4'd5;
    localparam logic [3:0] ST_WR_J  = 4'd6;
    localparam logic [3:0] ST_WR_I  = 4'd7;
    localparam logic [3:0] ST_RD_F  = 4'd8;
    localparam logic [3:0] ST_LAT_F = 4'd9;
    localparam logic [3:0] ST_WR_D  = 4'd10;
    localparam logic [3:0] ST_NEXT  = 4'd11;
    localparam logic [3:0] ST_DONE  = 4'd12;

    // Index of the final message byte; k never needs to count past it.
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    logic [3:0]        state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        f_q, f_d;
    logic [7:0]        e_q, e_d;
    logic              msg_ok_q, msg_ok_d;

    logic [7:0]        plain;
    logic [7:0]        f_index;

    // Accepted plaintext alphabet: 'a'..'z' and space.
    function automatic logic is_text(input logic [7:0] b);
        return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
    endfunction

    assign plain   = f_q ^ e_q;
    assign f_index = si_q + sj_q;
    assign msg_ok  = msg_ok_q;

    // Sequencer and datapath next-state: one message byte per 11-state pass.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        si_d     = si_q;
        sj_d     = sj_q;
        f_d      = f_q;
        e_d      = e_q;
        msg_ok_d = msg_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    i_d      = 8'd0;
                    j_d      = 8'd0;
                    k_d      = '0;
                    msg_ok_d = 1'b1;
                    state_d  = ST_INC_I;
                end
            end
            ST_INC_I: begin
                i_d     = i_q + 8'd1;
                state_d = ST_RD_I;
            end
            ST_RD_I: state_d = ST_LAT_I;
            ST_LAT_I: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = ST_RD_J;
            end
            ST_RD_J: state_d = ST_LAT_J;
            ST_LAT_J: begin
                sj_d    = s_q;
                state_d = ST_WR_J;
            end
            // When i == j both writes hit one location with the same value,
            // so the swap degenerates to a harmless rewrite.
            ST_WR_J: state_d = ST_WR_I;
            ST_WR_I: state_d = ST_RD_F;
            ST_RD_F: state_d = ST_LAT_F;
            ST_LAT_F: begin
                f_d     = s_q;
                e_d     = rom_q;
                state_d = ST_WR_D;
            end
            ST_WR_D: begin
                if (!is_text(plain)) begin
                    msg_ok_d = 1'b0;
                end
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                // msg_ok_q already reflects the byte written in WR_D.
                if ((k_q == K_LAST) || (EARLY_ABORT && !msg_ok_q)) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + MSG_AW'(1);
                    state_d = ST_INC_I;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore memory interface: addresses and strobes decoded from state only.
    always_comb begin
        s_address   = 8'd0;
        s_data      = 8'd0;
        s_wen       = 1'b0;
        rom_address = '0;
        dec_address = '0;
        dec_data    = 8'd0;
        dec_wen     = 1'b0;
        finish      = 1'b0;
        case (state_q)
            ST_RD_I: s_address = i_q;
            ST_RD_J: s_address = j_q;
            ST_WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wen     = 1'b1;
            end
            ST_WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wen     = 1'b1;
            end
            ST_RD_F: begin
                s_address   = f_index;
                rom_address = k_q;
            end
            ST_WR_D: begin
                dec_address = k_q;
                dec_data    = plain;
                dec_wen     = 1'b1;
            end
            ST_DONE: finish = 1'b1;
            default: ;
        endcase
    end

    // State and datapath registers; reset aborts a run immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            i_q      <= 8'd0;
            j_q      <= 8'd0;
            k_q      <= '0;
            si_q     <= 8'd0;
            sj_q     <= 8'd0;
            f_q      <= 8'd0;
            e_q      <= 8'd0;
            msg_ok_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            f_q      <= f_d;
            e_q      <= e_d;
            msg_ok_q <= msg_ok_d;
        end
    end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: three instances (short run, early abort, full
// run) with behavioural S/ROM/RAM models and a plain RC4 reference.
module tb_rc4_prga_decrypt;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b0;
    logic          start_w    [3];
    logic          finish_w   [3];
    logic          msg_ok_w   [3];
    logic [7:0]    s_addr_w   [3];
    logic [7:0]    s_data_w   [3];
    logic          s_wen_w    [3];
    logic [7:0]    s_q_w      [3];
    logic [AW-1:0] rom_addr_w [3];
    logic [7:0]    rom_q_w    [3];
    logic [AW-1:0] dec_addr_w [3];
    logic [7:0]    dec_data_w [3];
    logic          dec_wen_w  [3];

    rc4_prga_decrypt #(.MSG_LEN(2), .MSG_AW(AW), .EARLY_ABORT(1'b0)) u_a (
        .clk(clk), .reset(reset), .start(start_w[0]), .finish(finish_w[0]), .msg_ok(msg_ok_w[0]),
        .s_address(s_addr_w[0]), .s_data(s_data_w[0]), .s_wen(s_wen_w[0]), .s_q(s_q_w[0]),
        .rom_address(rom_addr_w[0]), .rom_q(rom_q_w[0]),
        .dec_address(dec_addr_w[0]), .dec_data(dec_data_w[0]), .dec_wen(dec_wen_w[0]));
    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(AW), .EARLY_ABORT(1'b1)) u_b (
        .clk(clk), .reset(reset), .start(start_w[1]), .finish(finish_w[1]), .msg_ok(msg_ok_w[1]),
        .s_address(s_addr_w[1]), .s_data(s_data_w[1]), .s_wen(s_wen_w[1]), .s_q(s_q_w[1]),
        .rom_address(rom_addr_w[1]), .rom_q(rom_q_w[1]),
        .dec_address(dec_addr_w[1]), .dec_data(dec_data_w[1]), .dec_wen(dec_wen_w[1]));
    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(AW), .EARLY_ABORT(1'b0)) u_c (
        .clk(clk), .reset(reset), .start(start_w[2]), .finish(finish_w[2]), .msg_ok(msg_ok_w[2]),
        .s_address(s_addr_w[2]), .s_data(s_data_w[2]), .s_wen(s_wen_w[2]), .s_q(s_q_w[2]),
        .rom_address(rom_addr_w[2]), .rom_q(rom_q_w[2]),
        .dec_address(dec_addr_w[2]), .dec_data(dec_data_w[2]), .dec_wen(dec_wen_w[2]));

    int         lens [3];
    bit         eas  [3];
    logic [7:0] s_init   [3][256];
    logic [7:0] rom_init [3][32];
    logic [7:0] smem     [3][256];
    logic [7:0] decm     [3][32];
    logic [7:0] smod     [3][256];
    logic [7:0] ks_buf   [32];
    bit         load = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int act = 0;
    bit mute = 1'b0;
    bit quiet = 1'b0;
    int start_e = 0;
    int fin_cnt = 0;
    int last_fin [3];
    int expq [$];
    int finc_q [$];
    bit fino_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memories: address registered, data one cycle later.
    always @(posedge clk) begin
        for (int n = 0; n < 3; n++) begin
            if (load) begin
                for (int a = 0; a < 256; a++) smem[n][a] <= s_init[n][a];
                for (int a = 0; a < 32; a++) decm[n][a] <= 8'h00;
            end else begin
                if (s_wen_w[n]) smem[n][s_addr_w[n]] <= s_data_w[n];
                if (dec_wen_w[n]) decm[n][dec_addr_w[n]] <= dec_data_w[n];
            end
            s_q_w[n]   <= smem[n][s_addr_w[n]];
            rom_q_w[n] <= rom_init[n][rom_addr_w[n]];
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, a, e, $time);
        end
    endtask

    function automatic bit is_text(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    // Per-cycle compare against the reference expectations.
    task automatic tick();
        int e;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            chk("wen_exclusive", 32'(s_wen_w[n] & dec_wen_w[n]), 0);
            if (quiet || n != act) begin
                chk("idle_quiet", {29'd0, s_wen_w[n], dec_wen_w[n], finish_w[n]}, 0);
            end else if (!mute) begin
                if (dec_wen_w[n]) begin
                    chk("dec_pending", 32'(expq.size() != 0), 1);
                    if (expq.size() != 0) begin
                        e = expq.pop_front();
                        chk("dec_write", 32'({dec_addr_w[n], dec_data_w[n]}), e);
                    end
                end
                if (finish_w[n]) begin
                    fin_cnt++;
                    last_fin[n] = cyc;
                    chk("finish_pending", 32'(finc_q.size() != 0), 1);
                    if (finc_q.size() != 0) begin
                        chk("finish_cycle", cyc, finc_q.pop_front());
                        chk("msg_ok", 32'(msg_ok_w[n]), 32'(fino_q.pop_front()));
                    end
                end
            end
        end
    endtask

    // Plain RC4 PRGA over the reference copy of S; queues expected writes.
    task automatic model_run(input int n, input int st, output int fin);
        int i = 0;
        int j = 0;
        int cnt = 0;
        bit ok = 1'b1;
        logic [7:0] t;
        logic [7:0] p;
        for (int k = 0; k < lens[n]; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(smod[n][i])) % 256;
            t = smod[n][i]; smod[n][i] = smod[n][j]; smod[n][j] = t;
            p = smod[n][(int'(smod[n][i]) + int'(smod[n][j])) % 256] ^ rom_init[n][k];
            expq.push_back((k << 8) | int'(p));
            cnt++;
            if (!is_text(p)) ok = 1'b0;
            if (eas[n] && !ok) break;
        end
        fin = st + 11 * cnt;
        finc_q.push_back(fin);
        fino_q.push_back(ok);
    endtask

    task automatic keystream(input int n);
        logic [7:0] s [256];
        int i = 0;
        int j = 0;
        logic [7:0] t;
        for (int a = 0; a < 256; a++) s[a] = smod[n][a];
        for (int k = 0; k < 32; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(s[i])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            ks_buf[k] = s[(int'(s[i]) + int'(s[j])) % 256];
        end
    endtask

    // ROM = keystream ^ mostly-lowercase text; one byte in `bad` is random.
    task automatic set_rom_text(input int n, input int bad);
        logic [7:0] p;
        keystream(n);
        for (int k = 0; k < 32; k++) begin
            if (bad > 0 && $urandom_range(0, bad - 1) == 0) p = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 26) == 26) p = 8'h20;
            else p = 8'(8'h61 + $urandom_range(0, 25));
            rom_init[n][k] = ks_buf[k] ^ p;
        end
    endtask

    task automatic ksa(input int n);
        logic [7:0] key [3];
        int j = 0;
        logic [7:0] t;
        key[0] = 8'h00; key[1] = 8'h02; key[2] = 8'h49;
        for (int a = 0; a < 256; a++) s_init[n][a] = 8'(a);
        for (int a = 0; a < 256; a++) begin
            j = (j + int'(s_init[n][a]) + int'(key[a % 3])) % 256;
            t = s_init[n][a]; s_init[n][a] = s_init[n][j]; s_init[n][j] = t;
        end
    endtask

    task automatic load_mems();
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int n = 0; n < 3; n++)
            for (int a = 0; a < 256; a++) smod[n][a] = s_init[n][a];
    endtask

    task automatic check_s(input int n);
        int mism = 0;
        for (int a = 0; a < 256; a++) if (smem[n][a] !== smod[n][a]) mism++;
        chk("s_final", mism, 0);
    endtask

    task automatic do_run(input int n, input int pulse_at);
        int fin;
        act = n;
        start_e = cyc + 1;
        model_run(n, start_e, fin);
        start_w[n] = 1'b1;
        tick();
        start_w[n] = 1'b0;
        for (int t = 0; t < 11 * 32 + 20 && finc_q.size() != 0; t++) begin
            if (pulse_at > 0 && t == pulse_at) start_w[n] = 1'b1;
            tick();
            start_w[n] = 1'b0;
        end
        chk("run_complete", finc_q.size(), 0);
        expq.delete(); finc_q.delete(); fino_q.delete();
        quiet = 1'b1;
        repeat (20) tick();
        quiet = 1'b0;
        check_s(n);
    endtask

    initial begin
        int base, f1, f2;
        lens[0] = 2;  lens[1] = 32; lens[2] = 32;
        eas[0]  = 0;  eas[1]  = 1;  eas[2]  = 0;
        for (int n = 0; n < 3; n++) begin
            start_w[n] = 1'b0;
            last_fin[n] = 0;
            for (int a = 0; a < 256; a++) s_init[n][a] = 8'(a);
            for (int a = 0; a < 32; a++) rom_init[n][a] = 8'h00;
        end

        // Reset state
        #2 reset = 1'b1;
        repeat (2) tick();
        for (int n = 0; n < 3; n++) begin
            chk("rst_s_address", 32'(s_addr_w[n]), 0);
            chk("rst_s_data", 32'(s_data_w[n]), 0);
            chk("rst_s_wen", 32'(s_wen_w[n]), 0);
            chk("rst_rom_address", 32'(rom_addr_w[n]), 0);
            chk("rst_dec_bus", 32'({dec_addr_w[n], dec_data_w[n], dec_wen_w[n]}), 0);
            chk("rst_finish", 32'(finish_w[n]), 0);
            chk("rst_msg_ok", 32'(msg_ok_w[n]), 1);
        end
        reset = 1'b0;
        repeat (2) tick();

        // Identity S, zero ROM, two bytes
        load_mems();
        do_run(0, 0);
        chk("a1_dec0", 32'(decm[0][0]), 32'h02);
        chk("a1_dec1", 32'(decm[0][1]), 32'h05);
        chk("a1_s2", 32'(smem[0][2]), 32'h03);
        chk("a1_s3", 32'(smem[0][3]), 32'h02);
        chk("a1_msg_ok", 32'(msg_ok_w[0]), 0);

        // Identity S, plaintext "aa"
        load_mems();
        rom_init[0][0] = 8'h63; rom_init[0][1] = 8'h64;
        do_run(0, 0);
        chk("a2_dec0", 32'(decm[0][0]), 32'h61);
        chk("a2_dec1", 32'(decm[0][1]), 32'h61);
        chk("a2_msg_ok", 32'(msg_ok_w[0]), 1);
        chk("a2_finish_cycle", last_fin[0] - start_e + 1, 23);

        // Early abort on first byte
        load_mems();
        do_run(1, 0);
        chk("b1_dec0", 32'(decm[1][0]), 32'h02);
        chk("b1_dec1_untouched", 32'(decm[1][1]), 32'h00);
        chk("b1_finish_cycle", last_fin[1] - start_e + 1, 12);
        chk("b1_msg_ok", 32'(msg_ok_w[1]), 0);

        // Randomized early-abort runs with evolving S
        for (int r = 0; r < 6; r++) begin
            set_rom_text(1, 12);
            do_run(1, 0);
        end

        // Key-scheduled S (key 00 02 49): random ROM, then all-text ROM
        ksa(2);
        load_mems();
        for (int k = 0; k < 32; k++) rom_init[2][k] = 8'($urandom_range(0, 255));
        do_run(2, 0);
        load_mems();
        set_rom_text(2, 0);
        do_run(2, 0);
        chk("c_text_msg_ok", 32'(msg_ok_w[2]), 1);

        // start held through two full runs
        act = 2;
        start_e = cyc + 1;
        model_run(2, start_e, f1);
        model_run(2, f1 + 2, f2);
        base = fin_cnt;
        start_w[2] = 1'b1;
        repeat (2 * (11 * 32 + 2)) tick();
        start_w[2] = 1'b0;
        repeat (30) tick();
        chk("held_finishes", fin_cnt - base, 2);
        chk("held_queue", finc_q.size(), 0);
        expq.delete(); finc_q.delete(); fino_q.delete();
        check_s(2);

        // start pulsed mid-run is ignored
        base = fin_cnt;
        set_rom_text(2, 20);
        do_run(2, 40);
        chk("pulse_single_finish", fin_cnt - base, 1);

        // Randomized short runs
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 2; k++) rom_init[0][k] = 8'($urandom_range(0, 255));
            do_run(0, 0);
        end

        // Reset during WR_J of byte 3
        act = 2;
        mute = 1'b1;
        start_w[2] = 1'b1;
        tick();
        start_w[2] = 1'b0;
        repeat (27) tick();
        chk("pre_reset_s_wen", 32'(s_wen_w[2]), 1);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_s_bus", 32'({s_addr_w[2], s_data_w[2], s_wen_w[2]}), 0);
        chk("mid_rst_rom_address", 32'(rom_addr_w[2]), 0);
        chk("mid_rst_dec_bus", 32'({dec_addr_w[2], dec_data_w[2], dec_wen_w[2]}), 0);
        chk("mid_rst_finish", 32'(finish_w[2]), 0);
        chk("mid_rst_msg_ok", 32'(msg_ok_w[2]), 1);
        tick();
        reset = 1'b0;
        mute = 1'b0;
        quiet = 1'b1;
        repeat (40) tick();
        quiet = 1'b0;
        load_mems();
        set_rom_text(2, 0);
        do_run(2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
